// File: rtl/approx_arith_pkg.sv
// Shared constants and types for the approximate-multiplier
// characterisation blocks.
package approx_arith_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 2 * OP_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mon_state_t;

endpackage

// File: rtl/error_distance_unit.sv
// Combinational unsigned error distance |a - b|.
// Shared by the approximate-arithmetic monitors.
module error_distance_unit
    import approx_arith_pkg::*;
#(
    parameter int W = PROD_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] d
);

    assign d = (a >= b) ? (a - b) : (b - a);

endmodule

// File: rtl/approx_mult_error_monitor8.sv
// Error-metric monitor for 8x8 approximate multipliers: recomputes
// the exact product and accumulates count/sum/max of error distance.
module approx_mult_error_monitor8
    import approx_arith_pkg::*;
#(
    parameter int OP_W  = 8,
    parameter int CNT_W = 16,
    parameter int ACC_W = 32,
    localparam int PROD_W = 2 * OP_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  num_samples_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [OP_W-1:0]   op1_i,
    input  logic [OP_W-1:0]   op2_i,
    input  logic [PROD_W-1:0] approx_product_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  sample_count_o,
    output logic [CNT_W-1:0]  err_count_o,
    output logic [ACC_W-1:0]  err_sum_o,
    output logic              err_sum_sat_o,
    output logic [PROD_W-1:0] err_max_o
);

    localparam int SW = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

    mon_state_t state_q, state_d;

    logic [CNT_W-1:0]  n_q;
    logic              v0_q, v1_q;
    logic [OP_W-1:0]   op1_q, op2_q;
    logic [PROD_W-1:0] apx_q, ed_q;
    logic [PROD_W-1:0] exact, ed;
    logic              open_win, accept, last;
    logic [SW-1:0]     sum_ext;
    logic              sum_ovf;

    assign open_win = start_i & ((state_q == IDLE) | (state_q == DONE));
    assign ready_o  = (state_q == RUN) & (sample_count_o < n_q);
    assign accept   = valid_i & ready_o;
    assign last     = accept & ((sample_count_o + CNT_W'(1)) == n_q);

    assign busy_o = (state_q == RUN) | (state_q == DRAIN);
    assign done_o = (state_q == DONE);

    assign exact = PROD_W'(op1_q) * PROD_W'(op2_q);

    error_distance_unit #(.W(PROD_W)) u_edu (
        .a (exact),
        .b (apx_q),
        .d (ed)
    );

    assign sum_ext = SW'(err_sum_o) + SW'(ed_q);
    assign sum_ovf = sum_ext > SW'({ACC_W{1'b1}});

    // Window sequencing: empty windows skip straight to the drain check.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = (num_samples_i == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (last) state_d = DRAIN;
            end
            DRAIN: begin
                if (!v0_q && !v1_q) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Two-stage datapath: capture sample, then register error distance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v0_q  <= 1'b0;
            v1_q  <= 1'b0;
            op1_q <= '0;
            op2_q <= '0;
            apx_q <= '0;
            ed_q  <= '0;
        end else begin
            v0_q <= accept;
            v1_q <= v0_q;
            if (accept) begin
                op1_q <= op1_i;
                op2_q <= op2_i;
                apx_q <= approx_product_i;
            end
            if (v0_q) ed_q <= ed;
        end
    end

    // Window statistics; a new window clears everything and latches N.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            n_q            <= '0;
            sample_count_o <= '0;
            err_count_o    <= '0;
            err_sum_o      <= '0;
            err_sum_sat_o  <= 1'b0;
            err_max_o      <= '0;
        end else if (open_win) begin
            n_q            <= num_samples_i;
            sample_count_o <= '0;
            err_count_o    <= '0;
            err_sum_o      <= '0;
            err_sum_sat_o  <= 1'b0;
            err_max_o      <= '0;
        end else begin
            if (accept) sample_count_o <= sample_count_o + CNT_W'(1);
            if (v1_q) begin
                err_count_o <= err_count_o + CNT_W'(ed_q != '0);
                if (sum_ovf) begin
                    err_sum_o     <= {ACC_W{1'b1}};
                    err_sum_sat_o <= 1'b1;
                end else begin
                    err_sum_o <= ACC_W'(sum_ext);
                end
                if (ed_q > err_max_o) err_max_o <= ed_q;
            end
        end
    end

endmodule
